// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR and runs the instruction-memory handshake for the controller.
// Optional performance counters (fetch_count, stall_count) are enabled with IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int unsigned   TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          PCWrite,
  input  logic          PCWriteCond,
  input  logic [1:0]    PCSource,
  input  logic          IRWrite,
  input  logic [AW-1:0] alu_result,
  input  logic [AW-1:0] alu_out,
  input  logic          zero,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   instr_out,
  output logic [AW-1:0] pc,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]   fetch_count,
  output logic [31:0]   stall_count,
`endif
  output logic          stall,
  output logic          fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_e;

  localparam logic [3:0] TO_LIMIT = 4'(TIMEOUT);

  state_e        state_q;
  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   ir_q;
  logic [3:0]    tcnt_q;
  logic [3:0]    tcnt_inc;
  logic          err_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic          pc_en;
  logic          ir_load;

  assign tcnt_inc = tcnt_q + 4'd1;
  assign ir_load  = (state_q == S_REQ) && mem_ack;

  // The controller must freeze in the very cycle it raises IRWrite, hence the IDLE term.
  assign stall = (state_q == S_REQ) || (state_q == S_ERR) ||
                 ((state_q == S_IDLE) && IRWrite);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= 32'h0;
      tcnt_q     <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (IRWrite) begin
            mem_addr_q <= pc_q;
            mem_req_q  <= 1'b1;
            tcnt_q     <= 4'd0;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack arriving on the would-be timeout cycle still completes the fetch.
          if (mem_ack) begin
            ir_q      <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= S_DONE;
          end else if (tcnt_inc == TO_LIMIT) begin
            tcnt_q    <= tcnt_inc;
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= S_ERR;
          end else begin
            tcnt_q <= tcnt_inc;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_d  = pc_q;
    pc_en = !stall && (PCWrite || (PCWriteCond && zero));
    case (PCSource)
      2'b00:   pc_d = alu_result;
      2'b01:   pc_d = alu_out;
      2'b10:   pc_d = {pc_q[AW-1:26], ir_q[25:0]};
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (pc_en) begin
      pc_q <= pc_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= 32'h0;
      stall_count_q <= 32'h0;
    end else begin
      if (ir_load) fetch_count_q <= fetch_count_q + 32'd1;
      if (stall)   stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign instr_out = ir_q;
  assign pc        = pc_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus timeout and reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, PCWriteCond, IRWrite, zero, mem_ack;
  logic [1:0]  PCSource;
  logic [31:0] alu_result, alu_out, mem_rdata;
  logic        mem_req, stall, fetch_err;
  logic [31:0] mem_addr, instr_out, pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.AW(32), .RESET_PC(32'h0), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IRWrite(IRWrite),
    .alu_result(alu_result), .alu_out(alu_out), .zero(zero),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_out(instr_out), .pc(pc),
`ifdef IFU_PERF_CNT_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .stall(stall), .fetch_err(fetch_err)
  );

  typedef struct {
    logic        irw, pcw, pcwc;
    logic [1:0]  src;
    logic [31:0] ar, ao;
    logic        z, ack;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr, e_instr, e_pc;
    logic        e_stall;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic irw, logic pcw, logic pcwc, logic [1:0] src,
                              logic [31:0] ar, logic [31:0] ao, logic z, logic ack,
                              logic [31:0] rd, logic e_req, logic [31:0] e_addr,
                              logic [31:0] e_instr, logic [31:0] e_pc, logic e_stall);
    vec_t v;
    v.irw = irw; v.pcw = pcw; v.pcwc = pcwc; v.src = src; v.ar = ar; v.ao = ao;
    v.z = z; v.ack = ack; v.rd = rd; v.e_req = e_req; v.e_addr = e_addr;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    IRWrite = 0; PCWrite = 0; PCWriteCond = 0; PCSource = 2'b00;
    alu_result = 0; alu_out = 0; zero = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    // Rows: one clock cycle each; expectations are sampled before that cycle's rising edge.
    tbl[0]  = mk(0,0,0,2'd0,32'h0,32'h0,0,0,32'h0,             0,32'h0,32'h0,32'h0,0);
    tbl[1]  = mk(1,1,0,2'd0,32'h7,32'h0,0,1,32'hDEAD_BEEF,     0,32'h0,32'h0,32'h0,1);
    tbl[2]  = mk(1,0,0,2'd0,32'h0,32'h0,0,1,32'hE400_FFFE,     1,32'h0,32'h0,32'h0,1);
    tbl[3]  = mk(0,1,0,2'd0,32'h1,32'h0,0,0,32'h0,             0,32'h0,32'hE400_FFFE,32'h0,0);
    tbl[4]  = mk(1,0,0,2'd0,32'h0,32'h0,0,0,32'h0,             0,32'h0,32'hE400_FFFE,32'h1,1);
    tbl[5]  = mk(0,0,0,2'd0,32'h0,32'h0,0,1,32'h11,            1,32'h1,32'hE400_FFFE,32'h1,1);
    tbl[6]  = mk(0,1,0,2'd0,32'h2,32'h0,0,0,32'h0,             0,32'h1,32'h11,32'h1,0);
    tbl[7]  = mk(1,0,0,2'd0,32'h0,32'h0,0,0,32'h0,             0,32'h1,32'h11,32'h2,1);
    tbl[8]  = mk(0,0,0,2'd0,32'h0,32'h0,0,0,32'h0,             1,32'h2,32'h11,32'h2,1);
    tbl[9]  = mk(0,0,0,2'd0,32'h0,32'h0,0,1,32'h22,            1,32'h2,32'h11,32'h2,1);
    tbl[10] = mk(0,1,0,2'd0,32'h3,32'h0,0,0,32'h0,             0,32'h2,32'h22,32'h2,0);
    tbl[11] = mk(0,0,0,2'd0,32'h0,32'h0,0,1,32'hFFFF_FFFF,     0,32'h2,32'h22,32'h3,0);
    tbl[12] = mk(0,0,1,2'd1,32'h0,32'h10,0,0,32'h0,            0,32'h2,32'h22,32'h3,0);
    tbl[13] = mk(0,0,1,2'd1,32'h0,32'h10,1,0,32'h0,            0,32'h2,32'h22,32'h3,0);
    tbl[14] = mk(0,1,1,2'd1,32'h0,32'h20,0,0,32'h0,            0,32'h2,32'h22,32'h10,0);
    tbl[15] = mk(0,1,0,2'd3,32'h55,32'h0,0,0,32'h0,            0,32'h2,32'h22,32'h20,0);
    tbl[16] = mk(0,1,0,2'd0,32'hFFFF_FFFF,32'h0,0,0,32'h0,     0,32'h2,32'h22,32'h20,0);
    tbl[17] = mk(0,1,0,2'd0,32'h0,32'h0,0,0,32'h0,             0,32'h2,32'h22,32'hFFFF_FFFF,0);
    tbl[18] = mk(0,1,0,2'd0,32'h4000_0005,32'h0,0,0,32'h0,     0,32'h2,32'h22,32'h0,0);
    tbl[19] = mk(1,0,0,2'd0,32'h0,32'h0,0,0,32'h0,             0,32'h2,32'h22,32'h4000_0005,1);
    tbl[20] = mk(0,0,0,2'd0,32'h0,32'h0,0,1,32'h0400_0123,     1,32'h4000_0005,32'h22,32'h4000_0005,1);
    tbl[21] = mk(0,1,0,2'd2,32'h0,32'h0,0,0,32'h0,             0,32'h4000_0005,32'h0400_0123,32'h4000_0005,0);
    tbl[22] = mk(0,0,0,2'd0,32'h0,32'h0,0,0,32'h0,             0,32'h4000_0005,32'h0400_0123,32'h4000_0123,0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      IRWrite = tbl[i].irw; PCWrite = tbl[i].pcw; PCWriteCond = tbl[i].pcwc;
      PCSource = tbl[i].src; alu_result = tbl[i].ar; alu_out = tbl[i].ao;
      zero = tbl[i].z; mem_ack = tbl[i].ack; mem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("row%0d_mem_req", i), {31'b0, mem_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("row%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_instr", i), instr_out, tbl[i].e_instr);
      chk($sformatf("row%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("row%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
      chk($sformatf("row%0d_fetch_err", i), {31'b0, fetch_err}, 32'h0);
      @(negedge clk);
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch_count", fetch_count, 32'd4);
`endif

    // Ack on the 15th waiting cycle completes the fetch instead of timing out.
    drive_idle(); IRWrite = 1;
    #1 chk("late_ack_req_stall", {31'b0, stall}, 32'h1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); drive_idle();
      #1 chk($sformatf("late_ack_wait%0d", i), {30'b0, mem_req, stall}, 32'h3);
    end
    @(negedge clk); mem_ack = 1; mem_rdata = 32'hA5A5_0001;
    #1 chk("late_ack_req_still", {31'b0, mem_req}, 32'h1);
    @(negedge clk); drive_idle();
    #1;
    chk("late_ack_instr", instr_out, 32'hA5A5_0001);
    chk("late_ack_no_err", {31'b0, fetch_err}, 32'h0);
    chk("late_ack_stall", {31'b0, stall}, 32'h0);

    // Full timeout: 15 REQ cycles with no ack.
    @(negedge clk); IRWrite = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); drive_idle();
      #1 chk($sformatf("to_wait%0d", i), {30'b0, mem_req, fetch_err}, 32'h2);
    end
    @(negedge clk);
    #1;
    chk("to_fetch_err", {31'b0, fetch_err}, 32'h1);
    chk("to_stall", {31'b0, stall}, 32'h1);
    chk("to_mem_req", {31'b0, mem_req}, 32'h0);
    chk("to_instr", instr_out, 32'hA5A5_0001);
    PCWrite = 1; alu_result = 32'h1234; mem_ack = 1; mem_rdata = 32'hFFFF_0000; IRWrite = 1;
    @(negedge clk);
    @(negedge clk); drive_idle();
    #1;
    chk("err_hold_pc", pc, 32'h4000_0123);
    chk("err_hold_instr", instr_out, 32'hA5A5_0001);
    chk("err_hold_flag", {31'b0, fetch_err}, 32'h1);
    chk("err_hold_stall_req", {30'b0, mem_req, stall}, 32'h1);

    // Reset out of ERR, then reset again in the middle of a request.
    reset = 1'b0;
    #1 chk("err_rst_clear", {30'b0, fetch_err, stall}, 32'h0);
    @(negedge clk); reset = 1'b1; IRWrite = 1;
    @(negedge clk); drive_idle();
    #1 chk("mid_req_active", {31'b0, mem_req}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("mid_rst_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); reset = 1'b1; mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    #1;
    chk("post_rst_instr", instr_out, 32'h0);
    chk("post_rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("post_rst_pc", pc, 32'h0);
    drive_idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
